// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures period and high/low phase of a divided clock in system-clock cycles,
// with lock detection on repeated equal periods and sticky overflow on a stalled input.
module clk_ratio_meter #(
  parameter int RATIO_WIDTH = 8,
  parameter int LOCK_CNT    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_meas_clk,
  input  logic                   i_meas_en,
  output logic [RATIO_WIDTH-1:0] o_ratio,
  output logic [RATIO_WIDTH-1:0] o_high_cnt,
  output logic [RATIO_WIDTH-1:0] o_low_cnt,
  output logic                   o_valid,
  output logic                   o_locked,
  output logic                   o_overflow
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [RATIO_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);

  logic [1:0] state_q, state_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d, ratio_q, ratio_d, high_q, high_d, low_q, low_d;
  logic [MW-1:0] match_q, match_d;
  logic valid_q, valid_d, locked_q, locked_d, ovf_q, ovf_d;
  logic rise, fall, sat;

  // Next-state: edge detection, cycle counter, FSM, captures, lock and overflow tracking
  always_comb begin
    sync1_d  = i_meas_clk;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    rise     = sync2_q & ~hist_q;
    fall     = ~sync2_q & hist_q;
    sat      = cnt_q == CNT_MAX;
    state_d  = state_q;
    cnt_d    = rise ? RATIO_WIDTH'(1) : (sat ? cnt_q : cnt_q + 1'b1);
    ratio_d  = ratio_q;
    high_d   = high_q;
    low_d    = low_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    match_d  = match_q;
    if (!i_meas_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
      match_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
          end else if (sat) begin
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
          end
        end
        MEAS: begin
          if (rise) begin
            ratio_d  = cnt_q;
            low_d    = cnt_q - high_q;
            valid_d  = 1'b1;
            match_d  = (cnt_q == ratio_q) ? ((match_q == MATCH_MAX) ? match_q : match_q + 1'b1) : MW'(1);
            locked_d = match_d == MATCH_MAX;
          end else begin
            if (fall) high_d = cnt_q;
            if (sat) begin
              ovf_d    = 1'b1;
              locked_d = 1'b0;
              match_d  = '0;
              state_d  = ARM;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      cnt_q    <= '0;
      ratio_q  <= '0;
      high_q   <= '0;
      low_q    <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      high_q   <= high_d;
      low_q    <= low_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_ratio    = ratio_q;
  assign o_high_cnt = high_q;
  assign o_low_cnt  = low_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked_q;
  assign o_overflow = ovf_q;
endmodule
